instr_fetch_unit: RTL and testbench

Parametrised instruction fetch stage for the pipelined RISC-V core, placed between the program memory and the decode stage. Keeps its own PC and streams sequential fetches to a synchronous program memory with one-cycle read latency. Buffers returned words with their PCs in a small fetch queue and hands them to decode over a valid/ready handshake. Adds branch/jump redirect with flush of queued and in-flight words, and a halt that stops fetching after a configurable halt opcode.

---
 rtl/instr_fetch_unit.sv | 123 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues sequential reads to a
// one-cycle-latency program memory, and buffers returned words with their PCs
// in a small circular queue. Decode drains the queue over a valid/ready
// handshake. Redirects flush all queued and in-flight words. A configurable
// halt opcode stops fetching once that word has been enqueued.
module instr_fetch_unit #(
   parameter int               XLEN        = 32,
   parameter int               ADDR_W      = 12,
   parameter logic [XLEN-1:0]  RESET_PC    = '0,
   parameter int               QDEPTH      = 2,
   parameter logic [6:0]       HALT_OPCODE = 7'h7F
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [XLEN-1:0]   imem_rdata,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   output logic              if_valid,
   input  logic              if_ready,
   output logic [XLEN-1:0]   if_pc,
   output logic [XLEN-1:0]   if_instr,
   output logic              halted
);

   localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW = $clog2(QDEPTH + 1);

   // Request stage (p0) and response stage (p1) state.
   logic [XLEN-1:0] pc_p0;
   logic            inflight_p1;
   logic [XLEN-1:0] issued_pc_p1;
   logic            halted_r;

   // Fetch queue: data storage is not reset, only the pointers/count are.
   logic [XLEN-1:0] q_pc    [QDEPTH];
   logic [XLEN-1:0] q_instr [QDEPTH];
   logic [PW-1:0]   head;
   logic [PW-1:0]   tail;
   logic [CW-1:0]   count;
   logic            valid_r;

   logic            pop;
   logic            push;
   logic            halt_arriving;
   logic [CW:0]     occupancy;
   logic [CW-1:0]   count_next;

   // Low target bits are forced to zero, so they are intentionally not read.
   logic unused_redirect_lsbs;
   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Handshake, response acceptance and issue decision for this cycle.
   // No kill flag is kept: nothing is issued in a redirect cycle, so the only
   // response that must be discarded is the one arriving alongside the redirect.
   always_comb begin
      pop           = valid_r & if_ready;
      push          = inflight_p1 & ~redirect_valid;
      halt_arriving = inflight_p1 & (imem_rdata[6:0] == HALT_OPCODE);
      occupancy     = {1'b0, count} + (CW+1)'(inflight_p1) - (CW+1)'(pop);
      imem_req      = ~rst & ~halted_r & ~redirect_valid & ~halt_arriving &
                      (occupancy < (CW+1)'(QDEPTH));
      if (redirect_valid)
         count_next = '0;
      else
         count_next = count + CW'(push) - CW'(pop);
   end

   assign imem_addr = pc_p0[ADDR_W-1:0];
   assign if_valid  = valid_r;
   assign if_pc     = q_pc[head];
   assign if_instr  = q_instr[head];
   assign halted    = halted_r;

   // Control state: PC, in-flight flag, queue pointers/count and halt flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_p0       <= RESET_PC;
         inflight_p1 <= 1'b0;
         halted_r    <= 1'b0;
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         valid_r     <= 1'b0;
      end else begin
         inflight_p1 <= imem_req;
         count       <= count_next;
         valid_r     <= (count_next != '0);
         if (redirect_valid) begin
            pc_p0    <= {redirect_pc[XLEN-1:2], 2'b00};
            halted_r <= 1'b0;
            head     <= '0;
            tail     <= '0;
         end else begin
            if (imem_req)
               pc_p0 <= pc_p0 + XLEN'(4);
            if (push) begin
               tail <= ptr_inc(tail);
               if (halt_arriving)
                  halted_r <= 1'b1;
            end
            if (pop)
               head <= ptr_inc(head);
         end
      end
   end

   // Data path: remember the issued PC and write returned words into the queue.
   always_ff @(posedge clk) begin
      if (imem_req)
         issued_pc_p1 <= pc_p0;
      if (push) begin
         q_pc[tail]    <= issued_pc_p1;
         q_instr[tail] <= imem_rdata;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential stream, backpressure,
// redirect, halt, mid-stream reset and redirect racing a halt arrival.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [11:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        halted;

   logic        halt_en = 1'b0;
   logic [11:0] halt_addr = 12'h008;
   logic        watch_c = 1'b0;
   logic        saw_c = 1'b0;

   int errors = 0;
   int checks = 0;

   instr_fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_pc          (if_pc),
      .if_instr       (if_instr),
      .halted         (halted)
   );

   always #5 clk = ~clk;

   // Memory word for an address: address bits above the opcode, NOP or halt opcode.
   function automatic logic [31:0] mk(input logic [31:0] a, input logic h);
      return {a[24:0], (h ? 7'h7F : 7'h13)};
   endfunction

   // Synchronous program memory, one-cycle read latency.
   always @(posedge clk) begin
      if (imem_req)
         imem_rdata <= mk({20'b0, imem_addr}, halt_en && (imem_addr == halt_addr));
   end

   // Records any request to 0xC while watching the halt scenario.
   always @(posedge clk) begin
      if (watch_c && imem_req && imem_addr == 12'h00C)
         saw_c <= 1'b1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_head(input string tag, input logic [31:0] pc, input logic h);
      chk({tag, ".valid"}, 32'(if_valid), 32'd1);
      chk({tag, ".pc"}, if_pc, pc);
      chk({tag, ".instr"}, if_instr, mk(pc, h));
   endtask

   initial begin
      rst = 1'b1; if_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;

      // Reset state and sequential stream
      tick(); tick();
      chk("rst.req", 32'(imem_req), 32'd0);
      chk("rst.valid", 32'(if_valid), 32'd0);
      chk("rst.halted", 32'(halted), 32'd0);
      rst = 1'b0; #1;
      chk("seq.req0", 32'(imem_req), 32'd1);
      chk("seq.addr0", 32'(imem_addr), 32'h0);
      tick();
      chk("seq.lat", 32'(if_valid), 32'd0);
      chk("seq.addr1", 32'(imem_addr), 32'h4);
      tick();
      for (int k = 0; k < 6; k++) begin
         chk_head($sformatf("seq%0d", k), 32'(4 * k), 1'b0);
         tick();
      end

      // Backpressure: queue fills to two entries, requests stop
      rst = 1'b1; tick(); rst = 1'b0; if_ready = 1'b0; #1;
      for (int k = 0; k < 10; k++) begin
         if (k >= 2) chk($sformatf("bp.noreq%0d", k), 32'(imem_req), 32'd0);
         tick();
      end
      chk_head("bp.hold", 32'h0, 1'b0);
      chk("bp.req", 32'(imem_req), 32'd0);
      if_ready = 1'b1; #1;
      chk("bp.rel.req", 32'(imem_req), 32'd1);
      chk("bp.rel.addr", 32'(imem_addr), 32'h8);
      tick(); chk_head("bp.d1", 32'h4, 1'b0);
      tick(); chk_head("bp.d2", 32'h8, 1'b0);

      // Redirect with a word in the queue and a request in flight
      redirect_valid = 1'b1; redirect_pc = 32'h103; #1;
      chk("rd.noreq", 32'(imem_req), 32'd0);
      tick(); redirect_valid = 1'b0; #1;
      chk("rd.flush", 32'(if_valid), 32'd0);
      chk("rd.req", 32'(imem_req), 32'd1);
      chk("rd.addr", 32'(imem_addr), 32'h100);
      tick(); chk("rd.gap", 32'(if_valid), 32'd0);
      tick(); chk_head("rd.t0", 32'h100, 1'b0);
      tick(); chk_head("rd.t1", 32'h104, 1'b0);

      // Halt word at 0x8
      halt_en = 1'b1; halt_addr = 12'h008;
      rst = 1'b1; tick(); rst = 1'b0; watch_c = 1'b1;
      tick(); tick();
      chk_head("h.d0", 32'h0, 1'b0);
      tick();
      chk_head("h.d1", 32'h4, 1'b0);
      chk("h.arrive.noreq", 32'(imem_req), 32'd0);
      tick();
      chk_head("h.d2", 32'h8, 1'b1);
      chk("h.halted", 32'(halted), 32'd1);
      tick();
      chk("h.empty", 32'(if_valid), 32'd0);
      chk("h.still", 32'(halted), 32'd1);
      tick(); tick(); tick();
      chk("h.noreq", 32'(imem_req), 32'd0);
      redirect_valid = 1'b1; redirect_pc = 32'h20; #1;
      chk("h.rd.noreq", 32'(imem_req), 32'd0);
      tick(); redirect_valid = 1'b0; #1;
      chk("h.rd.halted", 32'(halted), 32'd0);
      chk("h.rd.req", 32'(imem_req), 32'd1);
      chk("h.rd.addr", 32'(imem_addr), 32'h20);
      tick(); tick();
      chk_head("h.res", 32'h20, 1'b0);
      chk("h.no_c", 32'(saw_c), 32'd0);
      watch_c = 1'b0;

      // Reset while halted with two entries queued
      halt_addr = 12'h004;
      rst = 1'b1; tick(); rst = 1'b0; if_ready = 1'b0;
      tick(); tick(); tick();
      chk("rs.pre.halted", 32'(halted), 32'd1);
      chk_head("rs.pre", 32'h0, 1'b0);
      rst = 1'b1; #1;
      chk("rs.req", 32'(imem_req), 32'd0);
      tick(); rst = 1'b0; if_ready = 1'b1; #1;
      chk("rs.valid", 32'(if_valid), 32'd0);
      chk("rs.halted", 32'(halted), 32'd0);
      chk("rs.req0", 32'(imem_req), 32'd1);
      chk("rs.addr0", 32'(imem_addr), 32'h0);
      tick(); tick();
      chk_head("rs.d0", 32'h0, 1'b0);

      // Redirect coincident with a pop and the halt word arriving
      halt_addr = 12'h008;
      rst = 1'b1; tick(); rst = 1'b0;
      tick(); tick(); tick();
      chk_head("c.pre", 32'h4, 1'b0);
      redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
      chk("c.noreq", 32'(imem_req), 32'd0);
      tick(); redirect_valid = 1'b0; #1;
      chk("c.valid", 32'(if_valid), 32'd0);
      chk("c.halted", 32'(halted), 32'd0);
      chk("c.req", 32'(imem_req), 32'd1);
      chk("c.addr", 32'(imem_addr), 32'h40);
      tick(); chk("c.gap", 32'(if_valid), 32'd0);
      tick(); chk_head("c.t0", 32'h40, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
